// File: rtl/sopc_inst_mem_ctrl.sv
// Loadable instruction memory for the test SOPC: the array is filled through a
// valid/ready load port while the CPU is held, then fetches are served with wait states.
module sopc_inst_mem_ctrl #(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DEPTH_LOG2  = 10,
  parameter int unsigned        WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0]  NOP_WORD    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [DATA_W-1:0]     inst_o,
  output logic                  stall_o,
  output logic                  cpu_hold_o,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [DEPTH_LOG2-1:0] ld_addr_i,
  input  logic [DATA_W-1:0]     ld_data_i,
  input  logic                  ld_done_i,
  output logic [DEPTH_LOG2:0]   ld_count_o,
  output logic                  err_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  // The IDLE miss cycle is itself the first stall cycle, so BUSY lasts WAIT_CYCLES
  // cycles and the counter starts one lower; zero wait states serve directly from IDLE.
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {LOAD, IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   lat_addr;
  logic [ADDR_W-1:0]   resp_addr;
  logic                resp_valid;
  logic [2:0]          wait_cnt;

  logic                hit;
  logic                abort;
  logic                start_miss;
  logic                serve;
  logic [ADDR_W-1:0]   serve_addr;
  logic                serve_bad;
  logic [DEPTH_LOG2-1:0] serve_idx;

  assign hit       = resp_valid && (resp_addr == addr_i);
  assign serve_bad = (serve_addr[1:0] != 2'b00) || ((serve_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign serve_idx = serve_addr[DEPTH_LOG2+1:2];

  always_comb begin
    state_nxt  = state;
    abort      = 1'b0;
    start_miss = 1'b0;
    serve      = 1'b0;
    serve_addr = lat_addr;
    cpu_hold_o = 1'b0;
    ld_ready_o = 1'b0;
    stall_o    = 1'b0;
    case (state)
      LOAD: begin
        cpu_hold_o = 1'b1;
        ld_ready_o = 1'b1;
        if (ld_done_i && !ld_start_i) state_nxt = IDLE;
      end
      IDLE: begin
        stall_o = ce_i && !hit;
        if (ld_start_i) begin
          abort     = 1'b1;
          state_nxt = LOAD;
        end else if (ce_i && !hit) begin
          if (WAIT_CYCLES == 0) begin
            serve      = 1'b1;
            serve_addr = addr_i;
          end else begin
            start_miss = 1'b1;
            state_nxt  = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = ce_i;
        if (ld_start_i) begin
          abort     = 1'b1;
          state_nxt = LOAD;
        end else if (wait_cnt == 3'd0) begin
          serve     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Array is deliberately left out of reset so a partial load survives it.
  always_ff @(posedge clk) begin
    if (state == LOAD && ld_valid_i) mem[ld_addr_i] <= ld_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      inst_o     <= NOP_WORD;
      ld_count_o <= '0;
      err_o      <= 1'b0;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      lat_addr   <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_nxt;

      if (state == LOAD) begin
        if (ld_start_i)
          ld_count_o <= {{DEPTH_LOG2{1'b0}}, ld_valid_i};
        else if (ld_valid_i && ld_count_o != COUNT_MAX)
          ld_count_o <= ld_count_o + 1'b1;
      end else if (abort) begin
        ld_count_o <= '0;
      end

      if (abort || start_miss) resp_valid <= 1'b0;
      else if (serve)          resp_valid <= 1'b1;

      if (serve) resp_addr <= serve_addr;

      if (start_miss) begin
        lat_addr <= addr_i;
        wait_cnt <= WAIT_LOAD;
      end else if (state == BUSY && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (abort)      inst_o <= NOP_WORD;
      else if (serve) inst_o <= serve_bad ? NOP_WORD : mem[serve_idx];

      if (serve && serve_bad) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sopc_inst_mem_ctrl.sv
// Bench for sopc_inst_mem_ctrl: one instance with one wait state and one with none,
// sharing stimulus, checked every cycle against a transaction-level model.
module tb_sopc_inst_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = '0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_done = 1'b0;

  logic [31:0] inst_q  [2];
  logic        stall_q [2];
  logic        hold_q  [2];
  logic        ready_q [2];
  logic [10:0] count_q [2];
  logic        err_q   [2];

  int tests = 0;
  int fails = 0;
  bit mdl_on = 1'b0;

  always #5 clk = ~clk;

  sopc_inst_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(1),
                       .NOP_WORD(32'h00000000)) u_w1 (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst_q[0]),
    .stall_o(stall_q[0]), .cpu_hold_o(hold_q[0]), .ld_start_i(ld_start),
    .ld_valid_i(ld_valid), .ld_ready_o(ready_q[0]), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .ld_done_i(ld_done), .ld_count_o(count_q[0]), .err_o(err_q[0]));

  sopc_inst_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0),
                       .NOP_WORD(32'h00000000)) u_w0 (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst_q[1]),
    .stall_o(stall_q[1]), .cpu_hold_o(hold_q[1]), .ld_start_i(ld_start),
    .ld_valid_i(ld_valid), .ld_ready_o(ready_q[1]), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .ld_done_i(ld_done), .ld_count_o(count_q[1]), .err_o(err_q[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int unsigned mw [2] = '{1, 0};
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  bit          m_load  [2];
  int          m_cnt   [2];
  logic [31:0] m_inst  [2];
  bit          m_ok    [2];
  bit          m_err   [2];
  bit          m_rv    [2];
  logic [31:0] m_ra    [2];
  bit          m_pend  [2];
  int          m_left  [2];
  logic [31:0] m_la    [2];

  task automatic m_deliver(input int k, input logic [31:0] a);
    bit bad;
    bad = (a % 4 != 0) || (a >= 32'h1000);
    if (bad) begin
      m_inst[k] = 32'h0;
      m_ok[k]   = 1'b1;
      m_err[k]  = 1'b1;
    end else begin
      m_inst[k] = m_mem[a / 4];
      m_ok[k]   = m_known[a / 4];
    end
    m_rv[k] = 1'b1;
    m_ra[k] = a;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_load[k] = 1'b1; m_cnt[k] = 0; m_inst[k] = 32'h0; m_ok[k] = 1'b1;
        m_err[k] = 1'b0; m_rv[k] = 1'b0; m_pend[k] = 1'b0; m_left[k] = 0;
      end
    end else begin
      if (m_load[0] && ld_valid) begin
        m_mem[ld_addr]   = ld_data;
        m_known[ld_addr] = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (m_load[k]) begin
          if (ld_start)                      m_cnt[k] = ld_valid ? 1 : 0;
          else if (ld_valid && m_cnt[k] < 1024) m_cnt[k]++;
          if (ld_done && !ld_start) m_load[k] = 1'b0;
        end else if (ld_start) begin
          m_load[k] = 1'b1; m_pend[k] = 1'b0; m_rv[k] = 1'b0; m_cnt[k] = 0;
          m_inst[k] = 32'h0; m_ok[k] = 1'b1;
        end else if (m_pend[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_pend[k] = 1'b0;
            m_deliver(k, m_la[k]);
          end
        end else if (ce && !(m_rv[k] && m_ra[k] == addr)) begin
          if (mw[k] == 0) m_deliver(k, addr);
          else begin
            m_pend[k] = 1'b1; m_left[k] = int'(mw[k]); m_la[k] = addr; m_rv[k] = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on && rst) begin
      for (int k = 0; k < 2; k++) begin
        bit exp_stall;
        exp_stall = ce && !m_load[k] && (m_pend[k] || !(m_rv[k] && m_ra[k] == addr));
        chk($sformatf("m%0d.stall", k), stall_q[k], exp_stall);
        chk($sformatf("m%0d.hold", k), hold_q[k], m_load[k]);
        chk($sformatf("m%0d.ready", k), ready_q[k], m_load[k]);
        chk($sformatf("m%0d.count", k), count_q[k], m_cnt[k]);
        chk($sformatf("m%0d.err", k), err_q[k], m_err[k]);
        if (m_ok[k]) chk($sformatf("m%0d.inst", k), inst_q[k], m_inst[k]);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm, input logic [31:0] a, input int e1, input int e0,
                       input logic [31:0] einst);
    int n1, n0;
    bit done;
    ce = 1'b1; addr = a; n1 = 0; n0 = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (stall_q[0]) n1++;
      if (stall_q[1]) n0++;
      if (!stall_q[0] && !stall_q[1]) done = 1'b1;
      else step();
    end
    chk({nm, ".stalls_w1"}, n1, e1);
    chk({nm, ".stalls_w0"}, n0, e0);
    chk({nm, ".inst_w1"}, inst_q[0], einst);
    chk({nm, ".inst_w0"}, inst_q[1], einst);
    step();
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s%0d.hold", nm, k), hold_q[k], 1'b1);
      chk($sformatf("%s%0d.ready", nm, k), ready_q[k], 1'b1);
      chk($sformatf("%s%0d.stall", nm, k), stall_q[k], 1'b0);
      chk($sformatf("%s%0d.inst", nm, k), inst_q[k], 32'h0);
      chk($sformatf("%s%0d.count", nm, k), count_q[k], 11'd0);
      chk($sformatf("%s%0d.err", nm, k), err_q[k], 1'b0);
    end
  endtask

  logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    #2 rst = 1'b1;
    mdl_on = 1'b1;
    step();

    // load 0..3, then release CPU
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 10'(i); ld_data = words[i];
      step();
    end
    ld_valid = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    chk("load.count", count_q[0], 11'd4);
    chk("load.hold", hold_q[0], 1'b0);
    chk("load.ready", ready_q[0], 1'b0);

    fetch("f8", 32'h8, 2, 1, 32'h33333333);
    fetch("f0", 32'h0, 2, 1, 32'h11111111);
    fetch("f4", 32'h4, 2, 1, 32'h22222222);
    fetch("f4hit", 32'h4, 0, 0, 32'h22222222);
    chk("good.err", err_q[0], 1'b0);

    fetch("mis6", 32'h6, 2, 1, 32'h0);
    chk("mis6.err_w1", err_q[0], 1'b1);
    chk("mis6.err_w0", err_q[1], 1'b1);
    fetch("fC", 32'hC, 2, 1, 32'h44444444);
    chk("fC.err_sticky", err_q[0], 1'b1);
    fetch("oor", 32'h1000, 2, 1, 32'h0);
    chk("oor.err", err_q[0], 1'b1);

    // reload while the one-wait instance is in BUSY
    addr = 32'h8;
    step();
    ld_start = 1'b1;
    @(negedge clk);
    chk("reload.busy_stall", stall_q[0], 1'b1);
    step();
    ld_start = 1'b0; ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reload%0d.hold", k), hold_q[k], 1'b1);
      chk($sformatf("reload%0d.ready", k), ready_q[k], 1'b1);
      chk($sformatf("reload%0d.inst", k), inst_q[k], 32'h0);
      chk($sformatf("reload%0d.count", k), count_q[k], 11'd0);
    end
    ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'hDEADBEEF; ld_done = 1'b1;
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
    chk("reload.count", count_q[0], 11'd1);
    chk("reload.released", hold_q[0], 1'b0);
    fetch("rf0", 32'h0, 2, 1, 32'hDEADBEEF);

    // asynchronous reset while BUSY
    addr = 32'h4;
    step();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_vals("arst");
    #1 rst = 1'b1;
    step();
    ce = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    fetch("arf0", 32'h0, 2, 1, 32'hDEADBEEF);
    fetch("arf4", 32'h4, 2, 1, 32'h22222222);
    chk("arst.err", err_q[0], 1'b0);

    // fill whole array, past saturation
    ce = 1'b0; ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      ld_valid = 1'b1; ld_addr = 10'(i); ld_data = $urandom;
      step();
    end
    ld_valid = 1'b0;
    chk("sat.count", count_q[0], 11'h400);
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int unsigned r;
      ld_start = ($urandom_range(0, 99) < 2);
      ld_done  = ($urandom_range(0, 9) == 0);
      ld_valid = $urandom_range(0, 1) != 0;
      ld_addr  = 10'($urandom_range(0, 15));
      ld_data  = $urandom;
      ce       = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 10)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (r < 15) addr = 32'h1000 | 32'($urandom_range(0, 15) * 4);
        else             addr = 32'($urandom_range(0, 15) * 4);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
